// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reads a multiplexed six-digit 7-segment bus back into
// BCD nibbles. Each enabled digit must be stable for SETTLE samples before
// it is captured; a frame is reported once all six positions are captured.
module seg_scan_capture #(
    parameter int SETTLE      = 4,
    parameter bit ENB_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  i_seg_enb,
    input  logic        i_seg_dp,
    input  logic [6:0]  i_seg,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_frame_vld,
    output logic        o_err_pat,
    output logic        o_err_enb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE_ST = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // cnt saturates at SETTLE; capture fires when the increment lands on SETTLE-1
    localparam logic [3:0] CNT_MAX = 4'(SETTLE);
    localparam logic [3:0] CAP_CNT = 4'(SETTLE - 2);

    logic [5:0]  s_enb, p_enb;
    logic        s_dp, p_dp;
    logic [6:0]  s_seg, p_seg;
    logic        same;
    logic        one_hot;
    logic        multi_hot;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        settle_done;
    logic        capture;
    logic        enb_err;

    logic [3:0]  nib;
    logic        pat_bad;

    logic [5:0]  mask;
    logic [23:0] shadow_dig, merged_dig;
    logic [5:0]  shadow_dp, merged_dp;
    logic        frame_done;

    assign same      = ({s_enb, s_dp, s_seg} == {p_enb, p_dp, p_seg});
    assign one_hot   = (s_enb != 6'd0) && ((s_enb & (s_enb - 6'd1)) == 6'd0);
    assign multi_hot = (s_enb != 6'd0) && !one_hot;

    // Input stage plus one-sample history; enables normalised to active-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_enb <= 6'd0;
            s_dp  <= 1'b0;
            s_seg <= 7'd0;
            p_enb <= 6'd0;
            p_dp  <= 1'b0;
            p_seg <= 7'd0;
        end else begin
            s_enb <= ENB_ACT_LOW ? ~i_seg_enb : i_seg_enb;
            s_dp  <= i_seg_dp;
            s_seg <= i_seg;
            p_enb <= s_enb;
            p_dp  <= s_dp;
            p_seg <= s_seg;
        end
    end

    // State and stability counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and settle logic: any change restarts the count
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        settle_done = 1'b0;
        if (!same) begin
            cnt_next   = 4'd0;
            state_next = (s_enb == 6'd0) ? IDLE : SETTLE_ST;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = 4'd0;
                    if (s_enb != 6'd0) begin
                        state_next = SETTLE_ST;
                    end
                end
                SETTLE_ST: begin
                    cnt_next = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 4'd1;
                    if (cnt == CAP_CNT) begin
                        settle_done = 1'b1;
                        state_next  = HOLD;
                    end
                end
                HOLD: begin
                    cnt_next = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 4'd1;
                end
                default: begin
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign capture = settle_done && one_hot;
    assign enb_err = settle_done && multi_hot;

    // Segment pattern to nibble; blank maps to F, anything unknown to E
    always_comb begin
        nib     = 4'hE;
        pat_bad = 1'b0;
        case (s_seg)
            7'h7E: nib = 4'h0;
            7'h30: nib = 4'h1;
            7'h6D: nib = 4'h2;
            7'h79: nib = 4'h3;
            7'h33: nib = 4'h4;
            7'h5B: nib = 4'h5;
            7'h5F: nib = 4'h6;
            7'h70: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h7B: nib = 4'h9;
            7'h00: nib = 4'hF;
            default: pat_bad = 1'b1;
        endcase
    end

    // Shadow with the current sample merged into its slot, used for both the
    // shadow update and the frame copy so the final slot is included
    always_comb begin
        merged_dig = shadow_dig;
        merged_dp  = shadow_dp;
        for (int k = 0; k < 6; k++) begin
            if (s_enb[k]) begin
                merged_dig[4*k +: 4] = nib;
                merged_dp[k]         = s_dp;
            end
        end
    end

    assign frame_done = capture && ((mask | s_enb) == 6'h3F);

    // Capture into the shadow, track coverage, publish completed frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask        <= 6'd0;
            shadow_dig  <= 24'd0;
            shadow_dp   <= 6'd0;
            o_digits    <= 24'd0;
            o_dp        <= 6'd0;
            o_frame_vld <= 1'b0;
            o_err_pat   <= 1'b0;
            o_err_enb   <= 1'b0;
        end else begin
            o_frame_vld <= 1'b0;
            o_err_pat   <= capture && pat_bad;
            o_err_enb   <= enb_err;
            if (capture) begin
                shadow_dig <= merged_dig;
                shadow_dp  <= merged_dp;
                if (frame_done) begin
                    mask        <= 6'd0;
                    o_digits    <= merged_dig;
                    o_dp        <= merged_dp;
                    o_frame_vld <= 1'b1;
                end else begin
                    mask <= mask | s_enb;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: the stimulus task models capture
// and queues each expected frame; a negedge monitor pops on o_frame_vld.
module tb_seg_scan_capture;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  i_seg_enb;
    logic        i_seg_dp;
    logic [6:0]  i_seg;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic        o_frame_vld;
    logic        o_err_pat;
    logic        o_err_enb;

    seg_scan_capture #(.SETTLE(SETTLE), .ENB_ACT_LOW(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_seg_enb  (i_seg_enb),
        .i_seg_dp   (i_seg_dp),
        .i_seg      (i_seg),
        .o_digits   (o_digits),
        .o_dp       (o_dp),
        .o_frame_vld(o_frame_vld),
        .o_err_pat  (o_err_pat),
        .o_err_enb  (o_err_enb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [23:0] expDigitsQ[$];
    logic [5:0]  expDpQ[$];
    logic [23:0] mShadow = 24'd0;
    logic [5:0]  mDp = 6'd0;
    logic [5:0]  mMask = 6'd0;
    logic [23:0] lastDigits = 24'd0;
    logic [5:0]  lastDp = 6'd0;
    int expFrames = 0, expErrPat = 0, expErrEnb = 0;
    int obsFrames = 0, obsErrPat = 0, obsErrEnb = 0;

    logic [6:0] segOf[10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    int pow10[6] = '{1, 10, 100, 1000, 10000, 100000};
    int counterVals[7] = '{0, 7, 42, 1234, 98765, 999999, 100005};

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one bus value for 'cycles' clocks (enb given active-high) and
    // predict whether it is captured, flagged or completes a frame
    task automatic applyStimulus(input logic [5:0] enb, input logic [6:0] seg,
                                 input logic dp, input int cycles, input logic [3:0] nibExp);
        @(negedge clk);
        i_seg_enb = ~enb;
        i_seg     = seg;
        i_seg_dp  = dp;
        if (cycles >= SETTLE && enb != 6'd0) begin
            if ($countones(enb) == 1) begin
                for (int k = 0; k < 6; k++) begin
                    if (enb[k]) begin
                        mShadow[4*k +: 4] = nibExp;
                        mDp[k] = dp;
                    end
                end
                mMask = mMask | enb;
                if (nibExp == 4'hE) expErrPat++;
                if (mMask == 6'h3F) begin
                    expDigitsQ.push_back(mShadow);
                    expDpQ.push_back(mDp);
                    lastDigits = mShadow;
                    lastDp = mDp;
                    expFrames++;
                    mMask = 6'd0;
                end
            end else begin
                expErrEnb++;
            end
        end
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        applyStimulus(6'd0, 7'd0, 1'b0, cycles, 4'hF);
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_err_pat) obsErrPat++;
            if (o_err_enb) obsErrEnb++;
            if (o_frame_vld) begin
                obsFrames++;
                if (expDigitsQ.size() == 0) begin
                    checkOutput("frame_unexpected", 32'd1, 32'd0);
                end else begin
                    checkOutput("frame_digits", {8'd0, o_digits}, {8'd0, expDigitsQ.pop_front()});
                    checkOutput("frame_dp", {26'd0, o_dp}, {26'd0, expDpQ.pop_front()});
                end
            end
        end
    end

    initial begin
        int v, d, k;
        logic blank;
        rst_n     = 1'b0;
        i_seg_enb = 6'h3F;
        i_seg     = 7'd0;
        i_seg_dp  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_digits", {8'd0, o_digits}, 32'd0);
        checkOutput("rst_dp", {26'd0, o_dp}, 32'd0);
        checkOutput("rst_vld", {31'd0, o_frame_vld}, 32'd0);
        checkOutput("rst_err_pat", {31'd0, o_err_pat}, 32'd0);
        checkOutput("rst_err_enb", {31'd0, o_err_enb}, 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Basic "123456" frame, 8 cycles per digit
        applyStimulus(6'b000001, 7'h30, 1'b0, 8, 4'h1);
        applyStimulus(6'b000010, 7'h6D, 1'b0, 8, 4'h2);
        applyStimulus(6'b000100, 7'h79, 1'b0, 8, 4'h3);
        applyStimulus(6'b001000, 7'h33, 1'b0, 8, 4'h4);
        applyStimulus(6'b010000, 7'h5B, 1'b0, 8, 4'h5);
        applyStimulus(6'b100000, 7'h5F, 1'b0, 8, 4'h6);
        idle(6);
        checkOutput("frame1_value", {8'd0, o_digits}, 32'h654321);

        // Glitch on position 2: a 3-cycle 7F is ignored, then 79 is taken
        applyStimulus(6'b000001, 7'h7E, 1'b0, 8, 4'h0);
        applyStimulus(6'b000010, 7'h6D, 1'b1, 8, 4'h2);
        applyStimulus(6'b000100, 7'h7F, 1'b0, SETTLE - 1, 4'h8);
        applyStimulus(6'b000100, 7'h79, 1'b0, 8, 4'h3);
        applyStimulus(6'b001000, 7'h33, 1'b0, 8, 4'h4);
        applyStimulus(6'b010000, 7'h5B, 1'b0, 8, 4'h5);
        applyStimulus(6'b100000, 7'h70, 1'b0, 8, 4'h7);
        idle(6);

        // Invalid pattern on position 4, back-to-back at minimum dwell
        applyStimulus(6'b000001, 7'h7B, 1'b0, SETTLE, 4'h9);
        applyStimulus(6'b000010, 7'h7F, 1'b0, SETTLE, 4'h8);
        applyStimulus(6'b000100, 7'h70, 1'b0, SETTLE, 4'h7);
        applyStimulus(6'b001000, 7'h5F, 1'b0, SETTLE, 4'h6);
        applyStimulus(6'b010000, 7'h01, 1'b0, SETTLE, 4'hE);
        applyStimulus(6'b100000, 7'h00, 1'b1, SETTLE, 4'hF);
        idle(6);
        checkOutput("err_pat_count", obsErrPat, expErrPat);

        // Multi-hot enables: flagged once, no capture, coverage untouched
        applyStimulus(6'b000001, 7'h30, 1'b0, 6, 4'h1);
        applyStimulus(6'b000010, 7'h30, 1'b0, 6, 4'h1);
        applyStimulus(6'b000011, 7'h30, 1'b0, 10, 4'h1);
        applyStimulus(6'b000100, 7'h6D, 1'b0, 6, 4'h2);
        applyStimulus(6'b001000, 7'h6D, 1'b0, 6, 4'h2);
        applyStimulus(6'b010000, 7'h6D, 1'b0, 6, 4'h2);
        applyStimulus(6'b100000, 7'h6D, 1'b0, 6, 4'h2);
        idle(6);
        checkOutput("err_enb_count", obsErrEnb, expErrEnb);

        // Running counter with leading-zero blanking, alternating scan order
        for (int n = 0; n < 7; n++) begin
            v = counterVals[n];
            for (int j = 0; j < 6; j++) begin
                k = (n % 2 == 1) ? 5 - j : j;
                d = (v / pow10[k]) % 10;
                blank = (k > 0) && (v < pow10[k]);
                applyStimulus(6'(1 << k), blank ? 7'h00 : segOf[d],
                              (k == 3) && (n % 2 == 1), 5,
                              blank ? 4'hF : 4'(d));
            end
            idle(3);
        end
        idle(4);

        // Reset after three captures; the partial frame must be discarded
        applyStimulus(6'b000001, 7'h7F, 1'b0, 6, 4'h8);
        applyStimulus(6'b000010, 7'h7F, 1'b0, 6, 4'h8);
        applyStimulus(6'b000100, 7'h7F, 1'b0, 6, 4'h8);
        idle(3);
        @(negedge clk);
        rst_n = 1'b0;
        mMask = 6'd0;
        mShadow = 24'd0;
        mDp = 6'd0;
        lastDigits = 24'd0;
        lastDp = 6'd0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_digits", {8'd0, o_digits}, 32'd0);
        rst_n = 1'b1;
        idle(3);
        applyStimulus(6'b001000, 7'h33, 1'b0, 6, 4'h4);
        applyStimulus(6'b010000, 7'h5B, 1'b0, 6, 4'h5);
        applyStimulus(6'b100000, 7'h5F, 1'b0, 6, 4'h6);
        applyStimulus(6'b000001, 7'h30, 1'b0, 6, 4'h1);
        applyStimulus(6'b000010, 7'h6D, 1'b0, 6, 4'h2);
        applyStimulus(6'b000100, 7'h79, 1'b0, 6, 4'h3);
        idle(10);

        checkOutput("hold_digits", {8'd0, o_digits}, {8'd0, lastDigits});
        checkOutput("hold_dp", {26'd0, o_dp}, {26'd0, lastDp});
        checkOutput("frame_count", obsFrames, expFrames);
        checkOutput("err_pat_total", obsErrPat, expErrPat);
        checkOutput("err_enb_total", obsErrEnb, expErrEnb);
        checkOutput("queue_empty", expDigitsQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
